// File: rtl/numarator_pkg.sv
// ============================================================================
// Module      : numarator_pkg
// Description : Shared constants and next-operation decode for the counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package numarator_pkg;

    localparam int unsigned c_default_width = 5;
    localparam int unsigned c_reset_value   = 0;

    typedef enum logic [1:0] {
        op_reset = 2'd0,
        op_load  = 2'd1,
        op_count = 2'd2,
        op_hold  = 2'd3
    } op_e;

    // Resolves the per-edge priority: reset low, then load, then count enable.
    function automatic op_e decode_op(input logic reset_n, input logic load,
                                      input logic en);
        if (!reset_n)
            return op_reset;
        else if (load)
            return op_load;
        else if (en)
            return op_count;
        else
            return op_hold;
    endfunction

endpackage

`default_nettype wire

// File: rtl/numarator.sv
// ============================================================================
// Module      : numarator
// Description : Loadable up/down wrap-around counter, synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module numarator
    import numarator_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width
) (
    input  logic             ck,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             en,
    input  logic             UpDown,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    op_e              w_op;

    assign w_op = decode_op(reset, load, en);

    // Modulo arithmetic falls out of the fixed register width; no saturation.
    always_comb begin
        w_next = r_count;
        unique case (w_op)
            op_reset: w_next = WIDTH'(c_reset_value);
            op_load:  w_next = in;
            op_count: w_next = UpDown ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
            op_hold:  w_next = r_count;
            default:  w_next = r_count;
        endcase
    end

    always_ff @(posedge ck) begin
        r_count <= w_next;
    end

    assign out = r_count;

endmodule

`default_nettype wire

// File: tb/tb_numarator.sv
// ============================================================================
// Module      : tb_numarator
// Description : Self-checking bench with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_numarator;

    localparam int unsigned WIDTH = 5;
    localparam int          MODULUS = 32;

    logic             ck = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             load = 1'b0;
    logic             en = 1'b0;
    logic             UpDown = 1'b0;
    logic [WIDTH-1:0] out;

    int total = 0;
    int bad   = 0;
    int model = 0;

    numarator #(.WIDTH(WIDTH)) dut (
        .ck     (ck),
        .reset  (reset),
        .in     (in),
        .load   (load),
        .en     (en),
        .UpDown (UpDown),
        .out    (out)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive at the falling edge, let the model follow the rising edge, check 1 ns later.
    task automatic step(input string tag, input logic r, input logic l,
                        input logic e, input logic u, input logic [WIDTH-1:0] d);
        @(negedge ck);
        reset = r; load = l; en = e; UpDown = u; in = d;
        @(posedge ck);
        if (!r)
            model = 0;
        else if (l)
            model = int'(d);
        else if (e)
            model = u ? (model + 1) % MODULUS : (model + MODULUS - 1) % MODULUS;
        #1;
        chk(tag, out, WIDTH'(model));
    endtask

    initial begin
        // Reset held two edges while load/en are also active.
        step("rst_a", 1'b0, 1'b1, 1'b1, 1'b1, 5'd22);
        step("rst_b", 1'b0, 1'b1, 1'b1, 1'b1, 5'd22);

        // Load then hold.
        step("load22", 1'b1, 1'b1, 1'b0, 1'b0, 5'b10110);
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);

        // Count up through the 31 -> 0 wrap.
        for (int i = 0; i < 12; i++) step("up_wrap", 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        chk("up_end", out, 5'd2);

        // Count down through the 0 -> 31 wrap.
        step("load1", 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
        for (int i = 0; i < 3; i++) step("down_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        chk("down_end", out, 5'd30);

        // Load beats count; reset beats load.
        step("load10", 1'b1, 1'b1, 1'b0, 1'b0, 5'd10);
        step("load_pri", 1'b1, 1'b1, 1'b1, 1'b1, 5'd22);
        step("rst_pri", 1'b0, 1'b1, 1'b1, 1'b1, 5'd22);

        // Glitches on reset/en/UpDown between edges must not disturb the register.
        step("pre_glitch", 1'b1, 1'b1, 1'b0, 1'b0, 5'd17);
        @(negedge ck);
        load = 1'b0; en = 1'b1; UpDown = 1'b1;
        reset = 1'b0; #1;
        chk("glitch_mid", out, WIDTH'(model));
        reset = 1'b1; #1;
        en = 1'b0; UpDown = 1'b0;
        @(posedge ck); #1;
        chk("glitch_edge", out, WIDTH'(model));

        // Sweep all control combinations {reset, load, en, UpDown}.
        for (int c = 0; c < 16; c++) begin
            logic [3:0] v;
            v = 4'(c);
            for (int k = 0; k < 3; k++) step("sweep", v[3], v[2], v[1], v[0], 5'd22);
        end

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(15) != 0), ($urandom_range(7) == 0),
                 1'($urandom), 1'($urandom), WIDTH'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/numarator.md
NUMARATOR -- requirements
Module: numarator

Interface
REQ-001 Parameter: WIDTH, default 5, counter and data width in bits.
REQ-002 ck  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on rising edge of ck.
REQ-004 in  input  WIDTH  parallel load value.
REQ-005 load  input  1  active-high synchronous parallel load.
REQ-006 en  input  1  active-high count enable.
REQ-007 UpDown  input  1  count direction: 1 = up (+1), 0 = down (-1).
REQ-008 out  output  WIDTH  current count value.

Function
REQ-009 out SHALL be driven directly by the internal count register, with no combinational path from any input.
REQ-010 Priority at each rising edge of ck: reset low > load high > en high > hold.
REQ-011 reset == 0 at an edge: out SHALL become 0 on that edge, regardless of load, en, UpDown.
REQ-012 reset == 1 and load == 1: out SHALL become in on that edge, regardless of en and UpDown.
REQ-013 reset == 1, load == 0, en == 1, UpDown == 1: out SHALL become out+1 modulo 2^WIDTH.
REQ-014 reset == 1, load == 0, en == 1, UpDown == 0: out SHALL become out-1 modulo 2^WIDTH.
REQ-015 reset == 1, load == 0, en == 0: out SHALL hold its value.
REQ-016 Wrap-around: up from 2^WIDTH-1 (31) SHALL give 0; down from 0 SHALL give 2^WIDTH-1 (31); no flags, no saturation.
REQ-017 Latency: every load, count or reset effect SHALL be visible on out one ck edge after the inputs are sampled.
REQ-018 Changing UpDown or en between edges SHALL have no effect; only values at the rising edge matter.

Reset
REQ-019 Reset SHALL be synchronous and active-low; out reset value SHALL be 0.
REQ-020 An asynchronous change of reset between clock edges SHALL NOT alter out.
REQ-021 If reset is asserted during counting, the following edge SHALL force out to 0, discarding any simultaneous load or count.
REQ-022 Before the first reset, out is undefined; the bench SHALL apply reset or load before checking values.

Structure
REQ-023 A shared package numarator_pkg SHALL hold the default WIDTH constant (5) and the reset value constant (0).
REQ-024 The block SHALL be a single module with one WIDTH-bit register and next-state logic; no sub-module.

Verification
REQ-025 reset=0 for 2 edges with load=1, en=1, in=22 -> out=0.
REQ-026 reset=1, load=1, in=5'b10110 -> out=22 after one edge; then load=0, en=0 for 3 edges -> out stays 22.
REQ-027 From 22: en=1, UpDown=1 for 12 edges -> 23..31, 0, 1, 2 (wraps from 31 to 0).
REQ-028 Load 1, then en=1, UpDown=0 for 3 edges -> 0, 31, 30 (wraps from 0 to 31).
REQ-029 Simultaneous load=1, en=1, UpDown=1, in=22 while out=10 -> out=22; reset=0 with load=1 -> out=0.
REQ-030 Sweep all 16 combinations of {reset, load, en, UpDown}, each held several edges, with in=22; check each edge against REQ-010 to REQ-016.
